// File: rtl/pid_pkg.sv
// Shared types and helpers for the PID actuator stage.
package pid_pkg;

    // Signed control word produced by the PID stage.
    typedef logic signed [15:0] ctrl_t;

    // Driver operating state.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DEAD = 2'd2
    } pwm_state_t;

    // |v| in 17 bits so that -32768 maps to +32768 instead of wrapping.
    function automatic logic [16:0] ctrl_magnitude(input ctrl_t v);
        logic [16:0] ext;
        ext = {v[15], v};
        return v[15] ? (~ext + 17'd1) : ext;
    endfunction

endpackage

// File: rtl/pid_pwm_driver_if.sv
// Control/actuator bundle between the PID stage (master) and the PWM driver (slave).
interface pid_pwm_driver_if
    import pid_pkg::*;
#(
    parameter int CNT_W = 16
) ();

    logic             enable;
    ctrl_t            control_in;
    logic             control_valid;
    logic             pwm_out;
    logic             dir_out;
    logic [CNT_W-1:0] duty_q;
    logic             period_start;
    logic             sat_flag;

    modport master (
        output enable, control_in, control_valid,
        input  pwm_out, dir_out, duty_q, period_start, sat_flag
    );

    modport slave (
        input  enable, control_in, control_valid,
        output pwm_out, dir_out, duty_q, period_start, sat_flag
    );

endinterface

// File: rtl/pid_pwm_driver_counter.sv
// PWM period counter: counts 0..PERIOD-1 while running, holds at 0 otherwise,
// flags the last cycle of a period and registers the period-start pulse.
module pwm_period_counter #(
    parameter int PERIOD = 1000,
    parameter int CNT_W  = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             run_now,      // driver is in RUN this cycle
    input  logic             run_next,     // driver will be in RUN next cycle
    output logic [CNT_W-1:0] cnt_next,     // counter value after the coming edge
    output logic             boundary,     // this cycle is cnt==PERIOD-1 in RUN
    output logic             period_start  // registered: cnt==0 in RUN
);

    localparam logic [CNT_W-1:0] LAST = CNT_W'(PERIOD - 1);

    logic [CNT_W-1:0] cnt_q;

    // Next count: advance only when running across the edge; entering RUN or
    // leaving it always lands on 0.
    always_comb begin
        // NOTE: every always_comb output gets a default first so no path can infer a latch.
        cnt_next = '0;
        if (run_now && run_next && cnt_q != LAST) begin
            cnt_next = cnt_q + 1'b1;
        end
    end

    assign boundary = run_now && (cnt_q == LAST);

    // Counter and period-start pulse registered from the same next-state values.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_q        <= '0;
            period_start <= 1'b0;
        end else begin
            // NOTE: sequential state uses non-blocking assignments so all registers update together.
            cnt_q        <= cnt_next;
            period_start <= run_next && (cnt_next == '0);
        end
    end

endmodule

// File: rtl/pid_pwm_driver.sv
// PWM/direction driver downstream of the PID controller: saturates the control
// magnitude to the period, slew-limits duty once per period and routes every
// direction reversal through zero duty plus a dead-time gap.
module pid_pwm_driver
    import pid_pkg::*;
#(
    parameter int PERIOD   = 1000,
    parameter int CNT_W    = 16,
    parameter int MAX_STEP = 64,
    parameter int DEADTIME = 4
) (
    input  logic              clk,
    input  logic              reset,
    pid_pwm_driver_if.slave   bus
);

    localparam logic [CNT_W-1:0] PERIOD_C = CNT_W'(PERIOD);
    localparam logic [CNT_W-1:0] STEP_C   = CNT_W'(MAX_STEP);
    localparam int               DW       = (DEADTIME > 1) ? $clog2(DEADTIME) : 1;
    localparam logic [DW-1:0]    DEAD_END = DW'(DEADTIME - 1);

    pwm_state_t       state, state_d;
    logic [DW-1:0]    dead_cnt, dead_cnt_d;
    logic [CNT_W-1:0] duty, duty_d;
    logic             dir, dir_d;
    logic             pwm, pwm_d;
    ctrl_t            pending;
    logic [CNT_W-1:0] target;
    logic             sat;

    logic [16:0]      mag;
    logic             mag_over;
    logic             reversal;
    logic [CNT_W-1:0] cnt_next;
    logic             boundary;

    // Move cur toward tgt by at most MAX_STEP, never overshooting.
    function automatic logic [CNT_W-1:0] slew(input logic [CNT_W-1:0] cur,
                                              input logic [CNT_W-1:0] tgt);
        logic [CNT_W-1:0] diff;
        if (tgt > cur) begin
            diff = tgt - cur;
            return (diff > STEP_C) ? cur + STEP_C : tgt;
        end
        diff = cur - tgt;
        return (diff > STEP_C) ? cur - STEP_C : tgt;
    endfunction

    pwm_period_counter #(
        .PERIOD (PERIOD),
        .CNT_W  (CNT_W)
    ) u_counter (
        .clk          (clk),
        .reset        (reset),
        .run_now      (state == RUN),
        .run_next     (state_d == RUN),
        .cnt_next     (cnt_next),
        .boundary     (boundary),
        .period_start (bus.period_start)
    );

    assign mag      = ctrl_magnitude(bus.control_in);
    assign mag_over = 32'(mag) > 32'(PERIOD);
    // A zero word carries no sign, so it can never request a reversal.
    assign reversal = (pending != '0) && (pending[15] != dir);

    // Sample latch: last valid word in a period wins; target is pre-clamped.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pending <= '0;
            target  <= '0;
            sat     <= 1'b0;
        end else if (bus.control_valid) begin
            pending <= bus.control_in;
            target  <= mag_over ? PERIOD_C : CNT_W'(mag);
            sat     <= mag_over;
        end
    end

    // Next-state logic: enable gating, boundary slew, reversal and dead time.
    always_comb begin
        state_d    = state;
        dead_cnt_d = dead_cnt;
        duty_d     = duty;
        dir_d      = dir;
        if (!bus.enable) begin
            state_d    = IDLE;
            dead_cnt_d = '0;
            duty_d     = '0;
        end else begin
            case (state)
                IDLE: begin
                    state_d = RUN;
                    duty_d  = '0;
                end
                RUN: begin
                    if (boundary) begin
                        if (reversal && duty == '0) begin
                            state_d    = DEAD;
                            dead_cnt_d = '0;
                        end else begin
                            duty_d = slew(duty, reversal ? '0 : target);
                        end
                    end
                end
                DEAD: begin
                    if (dead_cnt == DEAD_END) begin
                        state_d    = RUN;
                        dead_cnt_d = '0;
                        dir_d      = ~dir;
                        duty_d     = '0;
                    end else begin
                        dead_cnt_d = dead_cnt + 1'b1;
                    end
                end
                default: begin
                    state_d = IDLE;
                    duty_d  = '0;
                end
            endcase
        end
        pwm_d = (state_d == RUN) && (cnt_next < duty_d);
    end

    // State and output registers; pwm and duty share the edge so they stay aligned.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= IDLE;
            dead_cnt <= '0;
            duty     <= '0;
            dir      <= 1'b0;
            pwm      <= 1'b0;
        end else begin
            state    <= state_d;
            dead_cnt <= dead_cnt_d;
            duty     <= duty_d;
            dir      <= dir_d;
            pwm      <= pwm_d;
        end
    end

    assign bus.pwm_out  = pwm;
    assign bus.dir_out  = dir;
    assign bus.duty_q   = duty;
    assign bus.sat_flag = sat;

endmodule

// File: tb/tb_pid_pwm_driver.sv
// Directed bench for pid_pwm_driver with PERIOD=100, MAX_STEP=10, DEADTIME=4.
module tb_pid_pwm_driver;
    import pid_pkg::*;

    localparam int PERIOD   = 100;
    localparam int CNT_W    = 16;
    localparam int MAX_STEP = 10;
    localparam int DEADTIME = 4;

    logic clk = 1'b0;
    logic reset;
    int   checks = 0;
    int   errors = 0;

    pid_pwm_driver_if #(.CNT_W(CNT_W)) bus_if ();

    pid_pwm_driver #(
        .PERIOD   (PERIOD),
        .CNT_W    (CNT_W),
        .MAX_STEP (MAX_STEP),
        .DEADTIME (DEADTIME)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus_if)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic sample(input int val);
        bus_if.control_in    = ctrl_t'(val);
        bus_if.control_valid = 1'b1;
        tick();
        bus_if.control_valid = 1'b0;
    endtask

    // Starts on a cnt==0 cycle, runs one full period, optionally latching a
    // sample in its first cycle, and checks duty and pwm high-time.
    task automatic run_period(input int exp_duty, input bit do_s, input int s_val);
        int hi;
        int ps;
        check("period_start_at_cnt0", 32'(bus_if.period_start), 1);
        check("duty_q", 32'(bus_if.duty_q), exp_duty);
        hi = 0;
        ps = 0;
        for (int i = 0; i < PERIOD; i++) begin
            if (bus_if.pwm_out) hi++;
            if (bus_if.period_start) ps++;
            if (i == 0 && do_s) begin
                bus_if.control_in    = ctrl_t'(s_val);
                bus_if.control_valid = 1'b1;
            end
            tick();
            bus_if.control_valid = 1'b0;
        end
        check("pwm_high_cycles", 32'(hi), exp_duty);
        check("period_start_count", 32'(ps), 1);
    endtask

    // Called on the first DEAD cycle; walks the gap and checks the exit.
    task automatic dead_window(input logic exp_dir);
        check("dead_entry_state", 32'(dut.state), 32'(DEAD));
        check("dead_entry_pwm", 32'(bus_if.pwm_out), 0);
        check("dead_entry_ps", 32'(bus_if.period_start), 0);
        for (int k = 1; k < DEADTIME; k++) begin
            tick();
            check("dead_state", 32'(dut.state), 32'(DEAD));
            check("dead_pwm", 32'(bus_if.pwm_out), 0);
            check("dead_cnt_held", 32'(dut.u_counter.cnt_q), 0);
        end
        tick();
        check("dead_exit_state", 32'(dut.state), 32'(RUN));
        check("dead_exit_dir", 32'(bus_if.dir_out), 32'(exp_dir));
        check("dead_exit_duty", 32'(bus_if.duty_q), 0);
        check("dead_exit_ps", 32'(bus_if.period_start), 1);
    endtask

    initial begin
        reset                = 1'b1;
        bus_if.enable        = 1'b0;
        bus_if.control_in    = '0;
        bus_if.control_valid = 1'b0;
        #1;
        check("rst_pwm", 32'(bus_if.pwm_out), 0);
        check("rst_dir", 32'(bus_if.dir_out), 0);
        check("rst_duty", 32'(bus_if.duty_q), 0);
        check("rst_ps", 32'(bus_if.period_start), 0);
        check("rst_sat", 32'(bus_if.sat_flag), 0);
        repeat (2) tick();
        reset = 1'b0;
        tick();
        check("idle_state", 32'(dut.state), 32'(IDLE));
        check("idle_pwm", 32'(bus_if.pwm_out), 0);

        // Ramp to +35 at 10 counts per period, then trim to 30.
        sample(35);
        check("sat_35", 32'(bus_if.sat_flag), 0);
        bus_if.enable = 1'b1;
        tick();
        check("run_state", 32'(dut.state), 32'(RUN));
        check("run_cnt0", 32'(dut.u_counter.cnt_q), 0);
        run_period(0, 0, 0);
        run_period(10, 0, 0);
        run_period(20, 0, 0);
        run_period(30, 0, 0);
        run_period(35, 1, 30);
        // Reversal to -20: slew down through zero, dead gap, then ramp negative.
        run_period(30, 1, -20);
        check("sat_m20", 32'(bus_if.sat_flag), 0);
        check("dir_before_rev", 32'(bus_if.dir_out), 0);
        run_period(20, 0, 0);
        run_period(10, 0, 0);
        run_period(0, 0, 0);
        dead_window(1'b1);
        run_period(0, 0, 0);
        run_period(10, 0, 0);
        // Zero command with dir=1: ramps down, no dead time, dir kept.
        run_period(20, 1, 0);
        check("sat_zero", 32'(bus_if.sat_flag), 0);
        run_period(10, 0, 0);
        run_period(0, 0, 0);
        check("zero_no_dead", 32'(dut.state), 32'(RUN));
        check("zero_dir_kept", 32'(bus_if.dir_out), 1);

        // Saturation: +500 clamps to 100 and reverses from duty 0.
        run_period(0, 1, 500);
        check("sat_500", 32'(bus_if.sat_flag), 1);
        dead_window(1'b0);
        for (int d = 0; d < PERIOD; d += MAX_STEP) run_period(d, 0, 0);
        run_period(100, 0, 0);
        run_period(100, 1, -32768);
        check("sat_min", 32'(bus_if.sat_flag), 1);
        check("rev_first_step", 32'(bus_if.duty_q), 90);
        check("rev_dir_unchanged", 32'(bus_if.dir_out), 0);

        // Enable drop mid-period.
        repeat (37) tick();
        bus_if.enable = 1'b0;
        tick();
        check("dis_state", 32'(dut.state), 32'(IDLE));
        check("dis_duty", 32'(bus_if.duty_q), 0);
        check("dis_pwm", 32'(bus_if.pwm_out), 0);
        check("dis_cnt", 32'(dut.u_counter.cnt_q), 0);
        check("dis_ps", 32'(bus_if.period_start), 0);
        check("dis_dir_kept", 32'(bus_if.dir_out), 0);

        // Sample landing on cnt==99 is deferred one boundary.
        sample(0);
        check("sat_idle_zero", 32'(bus_if.sat_flag), 0);
        bus_if.enable = 1'b1;
        tick();
        check("reen_ps", 32'(bus_if.period_start), 1);
        repeat (PERIOD - 1) tick();
        check("cnt_last", 32'(dut.u_counter.cnt_q), PERIOD - 1);
        sample(80);
        check("late_no_change", 32'(bus_if.duty_q), 0);
        check("late_ps", 32'(bus_if.period_start), 1);
        run_period(0, 0, 0);
        run_period(10, 0, 0);
        run_period(20, 0, 0);
        run_period(30, 0, 0);
        run_period(40, 0, 0);
        check("sat_80", 32'(bus_if.sat_flag), 0);
        check("pre_reset_duty", 32'(bus_if.duty_q), 50);

        // Asynchronous reset mid-period at duty 50.
        repeat (25) tick();
        check("pre_reset_pwm", 32'(bus_if.pwm_out), 1);
        reset = 1'b1;
        #1;
        check("arst_pwm", 32'(bus_if.pwm_out), 0);
        check("arst_duty", 32'(bus_if.duty_q), 0);
        check("arst_dir", 32'(bus_if.dir_out), 0);
        check("arst_ps", 32'(bus_if.period_start), 0);
        check("arst_state", 32'(dut.state), 32'(IDLE));
        check("arst_cnt", 32'(dut.u_counter.cnt_q), 0);
        bus_if.enable = 1'b0;
        tick();
        reset = 1'b0;
        tick();
        check("post_rst_idle", 32'(dut.state), 32'(IDLE));
        check("post_rst_pwm", 32'(bus_if.pwm_out), 0);
        bus_if.enable = 1'b1;
        tick();
        check("post_rst_run", 32'(dut.state), 32'(RUN));
        run_period(0, 0, 0);
        check("pending_cleared", 32'(bus_if.duty_q), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
